// File: rtl/prio_readout_ctrl_pkg.sv
// Shared constants and state encoding for the priority readout controller.
// MEM_SIZE_DEF is the per-channel address width used by default.
package prio_readout_ctrl_pkg;

    localparam int MEM_SIZE_DEF = 6;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/prio_readout_ctrl_enc.sv
// Lowest-index-first priority encoder: one-hot grant, binary index and any flag.
// All outputs are zero when en_i is low or no request is present.
module prio_enc_onehot #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        if (en_i) begin
            // Scan high to low so the lowest requesting index is written last and wins.
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    gnt_o    = '0;
                    gnt_o[i] = 1'b1;
                    idx_o    = IDX_W'(i);
                    any_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prio_readout_ctrl.sv
// Crossing sequencer and fixed-priority readout arbiter for NSRC channels:
// init/setup sequencing, one grant per cycle, registered {src, addr} read address, cycle budget.
module prio_readout_ctrl
    import prio_readout_ctrl_pkg::*;
#(
    parameter int NSRC         = 4,
    parameter int SRC_W        = 2,
    parameter int MEM_SIZE     = MEM_SIZE_DEF,
    parameter int SETUP_CYCLES = 2,
    parameter int MAX_CYCLES   = 40
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      ready,
    input  logic [NSRC-1:0]           has_dat,
    input  logic [NSRC*MEM_SIZE-1:0]  addr_in,
    output logic                      init,
    output logic                      setup,
    output logic [NSRC-1:0]           sel,
    output logic [SRC_W+MEM_SIZE-1:0] rd_addr,
    output logic                      rd_en,
    output logic                      busy,
    output logic                      done,
    output logic                      truncated
);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          setup_cnt_q, setup_cnt_d;
    logic [CNT_W-1:0]          run_cnt_q, run_cnt_d;
    logic                      truncated_q, truncated_d;
    logic                      rd_en_q;
    logic [SRC_W+MEM_SIZE-1:0] rd_addr_q;

    logic [MEM_SIZE-1:0]       addr_arr [NSRC];
    logic [NSRC-1:0]           gnt;
    logic [SRC_W-1:0]          gnt_idx;
    logic                      gnt_any;
    logic                      arb_en;

    for (genvar g = 0; g < NSRC; g++) begin : g_addr
        assign addr_arr[g] = addr_in[g*MEM_SIZE +: MEM_SIZE];
    end

    // A start in any state aborts the crossing, so it also suppresses the grant that cycle.
    assign arb_en = (state_q == ST_RUN) && ready && !start;

    prio_enc_onehot #(
        .N     (NSRC),
        .IDX_W (SRC_W)
    ) u_enc (
        .req_i (has_dat),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        run_cnt_d   = run_cnt_q;
        truncated_d = truncated_q;
        init        = 1'b0;
        setup       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_SETUP: begin
                setup = 1'b1;
                busy  = 1'b1;
                init  = (setup_cnt_q == CNT_W'(SETUP_CYCLES - 1));
                if (setup_cnt_q == '0) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                end else begin
                    setup_cnt_d = setup_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                run_cnt_d = run_cnt_q + 1'b1;
                // Drained takes precedence: truncation is only flagged while data remains.
                if (has_dat == '0) begin
                    state_d = ST_DONE;
                end else if (run_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d     = ST_DONE;
                    truncated_d = 1'b1;
                end
            end
            ST_DONE: begin
                done    = !start;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d     = ST_SETUP;
            setup_cnt_d = CNT_W'(SETUP_CYCLES - 1);
            truncated_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            run_cnt_q   <= '0;
            truncated_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            run_cnt_q   <= run_cnt_d;
            truncated_q <= truncated_d;
            rd_en_q     <= gnt_any;
            if (gnt_any) begin
                rd_addr_q <= {gnt_idx, addr_arr[gnt_idx]};
            end
        end
    end

    assign sel       = gnt;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign truncated = truncated_q;

endmodule
